des_round_engine: RTL
=====================

# des_round_engine

Iterative 16-round DES Feistel core, one round per clock. It sits directly downstream of the initial-permutation stage and consumes that stage's 64-bit output and its `status` flag as a load strobe. It requests one 48-bit subkey per round from the key-schedule block through a round index. It delivers the swapped pre-output block R16‖L16 to the final-permutation stage with the same single-shot `status` handshake.

## Interface
Parameters:
- `ROUNDS`, 16: number of Feistel rounds; fixed at 16 for DES, exposed only for bench use.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `set`  in  1  synchronous, active-high reset/re-arm. Has priority over every other input.
- `data_in`  in  [0:63]  IP output; bit 0 is DES bit 1. `[0:31]` is L0, `[32:63]` is R0.
- `in_valid`  in  1  level strobe, normally driven by the upstream `status`.
- `key_sub`  in  [0:47]  subkey for the round selected by `round_idx`. Must be valid combinationally in the same cycle.
- `round_idx`  out  [3:0]  subkey index requested this cycle (0 = K1).
- `busy`  out  1  high while rounds are executing.
- `data_out`  out  [0:63]  pre-output block {R16, L16}.
- `status`  out  1  result valid; held until `set`.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - On `in_valid`=1 and `set`=0: load L←`data_in[0:31]`, R←`data_in[32:63]`, cnt←0, `busy`←1, go to ROUND.
- ROUND, on each edge:
  - L←R
  - R←L ⊕ f(R, `key_sub`)
  - cnt←cnt+1
- Final round edge (cnt=15):
  - Write `data_out`←{L ⊕ f(R,key_sub), R}, i.e. {R16, L16}.
  - `status`←1, `busy`←0, go to DONE.
- f(R,K):
  - E-expand R from 32 to 48 bits, then XOR with K.
  - Apply 8 S-boxes, 6→4 bits each. Row is bits 1 and 6, column is bits 2–5, MSB-first.
  - Apply P-permutation, 32→32 bits.
- `round_idx` is driven combinationally as cnt. It equals 0 in IDLE and DONE.
- DONE:
  - `data_out` and `status` are held stable.
  - `in_valid` is ignored; the block is single-shot until the next `set`. This matches the upstream level-held `status`.
- `in_valid` during ROUND is ignored.
- `set`=1 at any edge:
  - L, R, cnt, `data_out` ← 0; `status`, `busy` ← 0; state IDLE.
  - Any round in progress is discarded.
- `set` and `in_valid` high in the same cycle: the reset wins and nothing is loaded.

## Timing
- Reset values: `data_out`=0, `status`=0, `busy`=0, `round_idx`=0.
- Acceptance edge E0 → rounds on E1..E16 → `status` high after E16.
  - Latency is 17 edges from the `in_valid` sample, with 16 round cycles.
- `key_sub` is sampled on the same edge as its `round_idx` value. The key schedule must be zero-latency relative to `round_idx`.
- One block per `set` cycle. Throughput is 1 block / (≥18 cycles incl. `set`).

## Configuration
- Macro `DES_DECRYPT_EN`.
- Defined:
  - Adds input `decrypt` (1 bit), sampled only at the acceptance edge and held internally for the whole operation.
  - When `decrypt`=1, `round_idx` = 15−cnt (K16 first). The datapath is otherwise identical.
- Undefined:
  - No `decrypt` port; encryption only.
  - `round_idx` = cnt.

## Structure
- Package `des_pkg` holds:
  - `DES_ROUNDS`=16
  - E table (48 entries)
  - P table (32 entries)
  - S-box table (8×64 4-bit constants)
  - `state_t` enum {IDLE, ROUND, DONE}
- Sub-module `des_f_function`: purely combinational f(R,K) using `des_pkg` tables. The engine instantiates it once and adds the FSM, counter and registers around it.

## Test plan
- Key 133457799BBCDFF1 (via key-schedule model), `data_in`=CC00CCFFF0AAF0AA, `in_valid` pulse:
  - After E1, L=F0AAF0AA, R=EF4A6544 with `key_sub`=1B02EFFC7072.
  - `status` rises exactly 16 cycles after acceptance with `data_out`=0A4CD99543423234.
- Same stimulus with `in_valid` held high after DONE for 20 cycles:
  - `data_out`/`status` unchanged, `busy`=0, `round_idx`=0 throughout.
- `set` asserted at the edge after round 7:
  - Next cycle `status`=0, `busy`=0, `data_out`=0, `round_idx`=0.
  - A fresh load then yields 0A4CD99543423234 on schedule.
- `set` and `in_valid` both high for one cycle, then `set` low with `in_valid` high:
  - No load on the first edge; acceptance occurs on the second edge.
  - `status` is high 17 edges after the first edge.
- With `DES_DECRYPT_EN`, `decrypt`=1, `data_in`=0A4CD99543423234, same key:
  - `round_idx` sequence is 15,14,…,0.
  - `data_out`=CC00CCFFF0AAF0AA.
- `round_idx` monitor on any run: values 0..15, each for exactly one cycle, with `busy`=1 throughout.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES constants: round count, E/P permutation tables, S-boxes and the engine state type.
// Permutation entries use DES 1-based bit numbering (1 = leftmost/MSB bit).
package des_pkg;

    localparam int DES_ROUNDS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [5:0] E_TABLE [0:47] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam logic [5:0] P_TABLE [0:31] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Each box is stored row-major: entry index = row*16 + column.
    localparam logic [3:0] S_BOX [0:7][0:63] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    // six[5] is the first (leftmost) bit of the group: row = first/last bits, column = middle four.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] six);
        return S_BOX[box][{six[5], six[0], six[4:1]}];
    endfunction

endpackage

// File: rtl/des_f_function.sv
// Combinational DES round function f(R,K): E-expansion, key mix, eight S-boxes, P-permutation.
module des_f_function
    import des_pkg::*;
(
    input  logic [0:31] i_r,
    input  logic [0:47] i_k,
    output logic [0:31] o_f
);

    logic [0:47] w_exp;
    logic [0:47] w_mix;
    logic [0:31] w_sbox;

    always_comb begin
        w_exp = '0;
        for (int i = 0; i < 48; i++) begin
            w_exp[i] = i_r[5'(E_TABLE[i] - 6'd1)];
        end
    end

    assign w_mix = w_exp ^ i_k;

    // Ascending vectors keep DES bit 1 at index 0, so each 6-bit slice is already MSB-first.
    always_comb begin
        w_sbox = '0;
        for (int j = 0; j < 8; j++) begin
            w_sbox[4*j +: 4] = sbox_lookup(3'(j), w_mix[6*j +: 6]);
        end
    end

    always_comb begin
        o_f = '0;
        for (int i = 0; i < 32; i++) begin
            o_f[i] = w_sbox[5'(P_TABLE[i] - 6'd1)];
        end
    end

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES Feistel core, one round per clock, single-shot until re-armed by set.
// Optional macro DES_DECRYPT_EN adds a decrypt input that walks the subkeys K16..K1.
module des_round_engine
    import des_pkg::*;
#(
    parameter int ROUNDS = DES_ROUNDS
) (
    input  logic        clk,
    input  logic        set,
    input  logic [0:63] data_in,
    input  logic        in_valid,
    input  logic [0:47] key_sub,
`ifdef DES_DECRYPT_EN
    input  logic        decrypt,
`endif
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic [0:63] data_out,
    output logic        status
);

    localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);

    state_t      r_state;
    logic [0:31] r_l;
    logic [0:31] r_r;
    logic [3:0]  r_cnt;
    logic [0:63] r_data_out;
    logic        r_status;
    logic        r_busy;
`ifdef DES_DECRYPT_EN
    logic        r_decrypt;
`endif

    logic [0:31] w_f;
    logic [0:31] w_new_r;
    logic [3:0]  w_round_idx;

    des_f_function u_f (
        .i_r (r_r),
        .i_k (key_sub),
        .o_f (w_f)
    );

    assign w_new_r = r_l ^ w_f;

    always_ff @(posedge clk) begin
        if (set) begin
            r_state    <= IDLE;
            r_l        <= '0;
            r_r        <= '0;
            r_cnt      <= '0;
            r_data_out <= '0;
            r_status   <= 1'b0;
            r_busy     <= 1'b0;
`ifdef DES_DECRYPT_EN
            r_decrypt  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_l     <= data_in[0:31];
                        r_r     <= data_in[32:63];
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ROUND;
`ifdef DES_DECRYPT_EN
                        r_decrypt <= decrypt;
`endif
                    end
                end
                ROUND: begin
                    r_l <= r_r;
                    r_r <= w_new_r;
                    // The last round skips the Feistel swap on output: {R16, L16}.
                    if (r_cnt == LAST_CNT) begin
                        r_data_out <= {w_new_r, r_r};
                        r_status   <= 1'b1;
                        r_busy     <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DONE:    r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_round_idx = '0;
        if (r_state == ROUND) begin
`ifdef DES_DECRYPT_EN
            w_round_idx = r_decrypt ? (LAST_CNT - r_cnt) : r_cnt;
`else
            w_round_idx = r_cnt;
`endif
        end
    end

    assign round_idx = w_round_idx;
    assign busy      = r_busy;
    assign status    = r_status;
    assign data_out  = r_data_out;

endmodule
